// File: rtl/debounce_pkg.sv
// Shared types and default timing for the multi-channel button debouncer.
package debounce_pkg;
  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_CHK_HIGH = 2'd1,
    ST_HIGH     = 2'd2,
    ST_CHK_LOW  = 2'd3
  } db_state_e;

  // Defaults sized for a 100 MHz clock: 20 ms debounce, 1 s hold, 200 ms repeat.
  localparam int DEF_THRESH   = 2000000;
  localparam int DEF_HOLD_CYC = 100000000;
  localparam int DEF_RPT_CYC  = 20000000;
endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, qualification FSM, hold timer and auto-repeat.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   THRESH   = DEF_THRESH,
  parameter int   HOLD_CYC = DEF_HOLD_CYC,
  parameter int   RPT_CYC  = DEF_RPT_CYC,
  parameter logic INV      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  input  logic i_rpt_en,
  output logic o_level,
  output logic o_press,
  output logic o_press_nxt,
  output logic o_release,
  output logic o_hold,
  output logic o_rpt
);
  localparam int DW = $clog2(THRESH + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int RW = $clog2(RPT_CYC + 1);
  localparam logic [DW-1:0] THR    = DW'(THRESH);
  localparam logic [HW-1:0] HCY    = HW'(HOLD_CYC);
  localparam logic [HW-1:0] HCY_M1 = HW'(HOLD_CYC - 1);
  localparam logic [RW-1:0] RCY_M1 = RW'(RPT_CYC - 1);

  logic [1:0]    r_sync;
  db_state_e     r_state, w_nstate;
  logic [DW-1:0] r_dcnt, w_dcnt_nxt, w_dinc;
  logic [HW-1:0] r_hcnt, w_hcnt_nxt;
  logic [RW-1:0] r_rcnt, w_rcnt_nxt;
  logic          r_level, r_press, r_release, r_hold, r_rpt;
  logic          w_smp, w_press_nxt, w_release_nxt, w_hold_nxt, w_rpt_nxt;
  logic          w_in_high, w_held;

  assign w_smp     = r_sync[1];
  // The counter is zero in the stable states, so the first differing sample counts as one.
  assign w_dinc    = (r_dcnt == THR) ? THR : r_dcnt + 1'b1;
  assign w_in_high = (r_state == ST_HIGH) || (r_state == ST_CHK_LOW);
  assign w_held    = (r_hcnt == HCY);

  always_comb begin
    w_nstate      = r_state;
    w_dcnt_nxt    = '0;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      ST_LOW, ST_CHK_HIGH: begin
        if (!w_smp) begin
          w_nstate = ST_LOW;
        end else if (w_dinc >= THR) begin
          w_nstate    = ST_HIGH;
          w_press_nxt = 1'b1;
        end else begin
          w_nstate   = ST_CHK_HIGH;
          w_dcnt_nxt = w_dinc;
        end
      end
      ST_HIGH, ST_CHK_LOW: begin
        if (w_smp) begin
          w_nstate = ST_HIGH;
        end else if (w_dinc >= THR) begin
          w_nstate      = ST_LOW;
          w_release_nxt = 1'b1;
        end else begin
          w_nstate   = ST_CHK_LOW;
          w_dcnt_nxt = w_dinc;
        end
      end
      default: w_nstate = ST_LOW;
    endcase
  end

  // A bounce back to HIGH from CHK_LOW keeps the hold timer running.
  always_comb begin
    w_hcnt_nxt = r_hcnt;
    w_rcnt_nxt = r_rcnt;
    w_hold_nxt = 1'b0;
    w_rpt_nxt  = 1'b0;
    if (!w_in_high || w_release_nxt) begin
      w_hcnt_nxt = '0;
      w_rcnt_nxt = '0;
    end else if (!w_held) begin
      w_hcnt_nxt = r_hcnt + 1'b1;
      w_hold_nxt = (r_hcnt == HCY_M1);
    end else if (!i_rpt_en) begin
      w_rcnt_nxt = '0;
    end else if (r_rcnt == RCY_M1) begin
      w_rcnt_nxt = '0;
      w_rpt_nxt  = 1'b1;
    end else begin
      w_rcnt_nxt = r_rcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= '0;
      r_state   <= ST_LOW;
      r_dcnt    <= '0;
      r_hcnt    <= '0;
      r_rcnt    <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_hold    <= 1'b0;
      r_rpt     <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_btn ^ INV};
      r_state   <= w_nstate;
      r_dcnt    <= w_dcnt_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_rcnt    <= w_rcnt_nxt;
      r_level   <= w_press_nxt | (r_level & ~w_release_nxt);
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_hold    <= w_hold_nxt;
      r_rpt     <= w_rpt_nxt;
    end
  end

  assign o_level     = r_level;
  assign o_press     = r_press;
  assign o_press_nxt = w_press_nxt;
  assign o_release   = r_release;
  assign o_hold      = r_hold;
  assign o_rpt       = r_rpt;
endmodule

// File: rtl/multi_debouncer.sv
// N_CH independent debounce channels plus a registered any-press flag.
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int              N_CH     = 4,
  parameter int              THRESH   = DEF_THRESH,
  parameter int              HOLD_CYC = DEF_HOLD_CYC,
  parameter int              RPT_CYC  = DEF_RPT_CYC,
  parameter logic [N_CH-1:0] INV_MASK = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] i_rpt_en,
  input  logic [N_CH-1:0] i_btn_in,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_hold,
  output logic [N_CH-1:0] o_rpt,
  output logic            o_any_press
);
  logic [N_CH-1:0] w_press_nxt;
  logic            r_any_press;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .THRESH  (THRESH),
      .HOLD_CYC(HOLD_CYC),
      .RPT_CYC (RPT_CYC),
      .INV     (INV_MASK[g])
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_btn      (i_btn_in[g]),
      .i_rpt_en   (i_rpt_en[g]),
      .o_level    (o_level[g]),
      .o_press    (o_press[g]),
      .o_press_nxt(w_press_nxt[g]),
      .o_release  (o_release[g]),
      .o_hold     (o_hold[g]),
      .o_rpt      (o_rpt[g])
    );
  end

  // Built from the channels' next-press terms so it lines up with o_press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_any_press <= 1'b0;
    else        r_any_press <= |w_press_nxt;
  end

  assign o_any_press = r_any_press;
endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer: 2 channels, THRESH=4, HOLD_CYC=12, RPT_CYC=5.
module tb_multi_debouncer;
  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_HOLD  = 2;
  localparam int K_RPT   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] rpt_en = 2'b00;
  logic [1:0] btn = 2'b10;  // ch1 is active-low, so 1 is idle
  logic [1:0] o_level, o_press, o_release, o_hold, o_rpt;
  logic       o_any_press;

  multi_debouncer #(
    .N_CH(2), .THRESH(4), .HOLD_CYC(12), .RPT_CYC(5), .INV_MASK(2'b10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_rpt_en(rpt_en), .i_btn_in(btn),
    .o_level(o_level), .o_press(o_press), .o_release(o_release),
    .o_hold(o_hold), .o_rpt(o_rpt), .o_any_press(o_any_press)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  typedef struct { int cyc; int kind; int ch; } ev_t;
  ev_t exp_q[$];

  task automatic expect_ev(input int c, input int k, input int ch);
    ev_t e;
    e.cyc = c; e.kind = k; e.ch = ch;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard: every cycle, pulses due now are popped and all pulse outputs compared.
  logic [1:0] m_p, m_r, m_h, m_t;
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      m_p = '0; m_r = '0; m_h = '0; m_t = '0;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc == cyc) begin
          case (exp_q[i].kind)
            K_PRESS: m_p[exp_q[i].ch] = 1'b1;
            K_REL:   m_r[exp_q[i].ch] = 1'b1;
            K_HOLD:  m_h[exp_q[i].ch] = 1'b1;
            default: m_t[exp_q[i].ch] = 1'b1;
          endcase
          exp_q.delete(i);
        end
      end
      checks += 5;
      if (o_press !== m_p) begin errors++; $display("FAIL press cyc=%0d got=%b exp=%b", cyc, o_press, m_p); end
      if (o_release !== m_r) begin errors++; $display("FAIL release cyc=%0d got=%b exp=%b", cyc, o_release, m_r); end
      if (o_hold !== m_h) begin errors++; $display("FAIL hold cyc=%0d got=%b exp=%b", cyc, o_hold, m_h); end
      if (o_rpt !== m_t) begin errors++; $display("FAIL rpt cyc=%0d got=%b exp=%b", cyc, o_rpt, m_t); end
      if (o_any_press !== (|m_p)) begin errors++; $display("FAIL any_press cyc=%0d got=%b exp=%b", cyc, o_any_press, |m_p); end
    end
  end

  task automatic test_reset;
    #2;
    checks += 2;
    if ({o_level, o_press, o_release, o_hold, o_rpt, o_any_press} !== 11'd0) begin
      errors++; $display("FAIL reset_async got=%b exp=0", {o_level, o_press, o_release, o_hold, o_rpt, o_any_press});
    end
    repeat (3) @(negedge clk);
    if ({o_level, o_press, o_release, o_hold, o_rpt, o_any_press} !== 11'd0) begin
      errors++; $display("FAIL reset_clocked got=%b exp=0", {o_level, o_press, o_release, o_hold, o_rpt, o_any_press});
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;
    wait_cyc(cyc + 10);
    checks++;
    if (o_level !== 2'b00) begin errors++; $display("FAIL idle_level got=%b exp=00", o_level); end
  endtask

  task automatic test_press;
    int e;
    e = cyc + 1;
    btn[0] = 1'b1;
    expect_ev(e + 5, K_PRESS, 0);
    wait_cyc(e + 4);
    checks++;
    if (o_level[0] !== 1'b0) begin errors++; $display("FAIL press_early_level got=%b exp=0", o_level[0]); end
    wait_cyc(e + 5);
    checks++;
    if (o_level[0] !== 1'b1) begin errors++; $display("FAIL press_level got=%b exp=1", o_level[0]); end
    wait_cyc(e + 7);
    btn[0] = 1'b0;
    expect_ev(e + 13, K_REL, 0);
    wait_cyc(e + 12);
    checks++;
    if (o_level[0] !== 1'b1) begin errors++; $display("FAIL release_early_level got=%b exp=1", o_level[0]); end
    wait_cyc(e + 13);
    checks++;
    if (o_level[0] !== 1'b0) begin errors++; $display("FAIL release_level got=%b exp=0", o_level[0]); end
    wait_cyc(e + 20);
  endtask

  task automatic test_glitch;
    for (int g = 0; g < 5; g++) begin
      btn[0] = 1'b1;
      repeat (3) @(negedge clk);
      btn[0] = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (o_level[0] !== 1'b0) begin errors++; $display("FAIL glitch_level round=%0d got=%b exp=0", g, o_level[0]); end
    end
    wait_cyc(cyc + 10);
  endtask

  task automatic test_hold_rpt;
    int e;
    rpt_en = 2'b10;
    e = cyc + 1;
    btn[1] = 1'b0;
    expect_ev(e + 5, K_PRESS, 1);
    expect_ev(e + 17, K_HOLD, 1);
    for (int k = 22; k <= 42; k += 5) expect_ev(e + k, K_RPT, 1);
    expect_ev(e + 45, K_REL, 1);
    wait_cyc(e + 39);
    btn[1] = 1'b1;
    wait_cyc(e + 44);
    checks++;
    if (o_level[1] !== 1'b1) begin errors++; $display("FAIL hold_level got=%b exp=1", o_level[1]); end
    wait_cyc(e + 45);
    checks++;
    if (o_level[1] !== 1'b0) begin errors++; $display("FAIL hold_release_level got=%b exp=0", o_level[1]); end
    wait_cyc(e + 55);
    rpt_en = 2'b00;
  endtask

  task automatic test_simul;
    int e;
    e = cyc + 1;
    btn = 2'b01;
    expect_ev(e + 5, K_PRESS, 0);
    expect_ev(e + 5, K_PRESS, 1);
    wait_cyc(e + 5);
    checks++;
    if (o_level !== 2'b11) begin errors++; $display("FAIL simul_level got=%b exp=11", o_level); end
    btn = 2'b10;
    expect_ev(e + 11, K_REL, 0);
    expect_ev(e + 11, K_REL, 1);
    wait_cyc(e + 11);
    checks++;
    if (o_level !== 2'b00) begin errors++; $display("FAIL simul_release_level got=%b exp=00", o_level); end
    wait_cyc(e + 20);
  endtask

  task automatic test_rpt_en;
    int e;
    rpt_en = 2'b01;
    e = cyc + 1;
    btn[0] = 1'b1;
    expect_ev(e + 5, K_PRESS, 0);
    expect_ev(e + 17, K_HOLD, 0);
    expect_ev(e + 22, K_RPT, 0);
    wait_cyc(e + 22);
    rpt_en[0] = 1'b0;
    wait_cyc(e + 24);
    rpt_en[0] = 1'b1;
    expect_ev(e + 29, K_RPT, 0);
    expect_ev(e + 34, K_RPT, 0);
    expect_ev(e + 39, K_RPT, 0);
    wait_cyc(e + 35);
    btn[0] = 1'b0;
    expect_ev(e + 41, K_REL, 0);
    wait_cyc(e + 50);
    rpt_en = 2'b00;
  endtask

  task automatic test_reset_mid;
    int e;
    // Reset during qualification: progress is lost, press re-qualifies after release.
    e = cyc + 1;
    btn[0] = 1'b1;
    wait_cyc(e + 4);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_level, o_press} !== 4'b0000) begin errors++; $display("FAIL rst_qual_outputs got=%b exp=0000", {o_level, o_press}); end
    wait_cyc(e + 6);
    rst_n = 1'b1;
    expect_ev(e + 12, K_PRESS, 0);
    wait_cyc(e + 11);
    checks++;
    if (o_level[0] !== 1'b0) begin errors++; $display("FAIL rst_qual_early_level got=%b exp=0", o_level[0]); end
    wait_cyc(e + 12);
    checks++;
    if (o_level[0] !== 1'b1) begin errors++; $display("FAIL rst_qual_level got=%b exp=1", o_level[0]); end
    wait_cyc(e + 14);
    btn[0] = 1'b0;
    expect_ev(e + 20, K_REL, 0);
    wait_cyc(e + 28);
    // Reset with level already high: must clear level asynchronously.
    e = cyc + 1;
    btn[0] = 1'b1;
    expect_ev(e + 5, K_PRESS, 0);
    wait_cyc(e + 8);
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_level !== 2'b00) begin errors++; $display("FAIL rst_high_level got=%b exp=00", o_level); end
    wait_cyc(e + 9);
    rst_n = 1'b1;
    expect_ev(e + 15, K_PRESS, 0);
    wait_cyc(e + 17);
    btn[0] = 1'b0;
    expect_ev(e + 23, K_REL, 0);
    wait_cyc(e + 32);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    test_reset;
    test_press;
    test_glitch;
    test_hold_rpt;
    test_simul;
    test_rpt_en;
    test_reset_mid;
    wait_cyc(cyc + 20);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d exp=finished", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 Parameter N_CH, default 4: number of independent button channels, range 1..32.
REQ-002 Parameter THRESH, default 2000000: consecutive differing synchronised samples needed to accept a new level (20 ms at 100 MHz), minimum 1.
REQ-003 Parameter HOLD_CYC, default 100000000: cycles of accepted-high level before a hold pulse (1 s), must exceed THRESH.
REQ-004 Parameter RPT_CYC, default 20000000: auto-repeat period after hold (200 ms), minimum 1.
REQ-005 Parameter INV_MASK, default all zeros, width N_CH: bit set means that channel's raw input is active-low and is inverted before synchronisation.
REQ-006 clk  input  1  system clock, all logic on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 rpt_en  input  N_CH  per-channel auto-repeat enable.
REQ-009 btn_in  input  N_CH  raw asynchronous button inputs.
REQ-010 level  output  N_CH  debounced (accepted) level per channel, registered.
REQ-011 press  output  N_CH  one-cycle pulse on accepted low-to-high transition.
REQ-012 release  output  N_CH  one-cycle pulse on accepted high-to-low transition.
REQ-013 hold  output  N_CH  one-cycle pulse when level has been high for HOLD_CYC cycles.
REQ-014 rpt  output  N_CH  one-cycle auto-repeat pulse.
REQ-015 any_press  output  1  registered OR of press, same cycle as press.

Function
REQ-016 Each channel shall pass btn_in (XOR INV_MASK) through a 2-flop synchroniser before any other logic.
REQ-017 Each channel shall run a 4-state FSM: LOW, CHK_HIGH, HIGH, CHK_LOW; LOW/HIGH are stable, CHK_* are qualification states.
REQ-018 LOW -> CHK_HIGH when synchronised input is 1; CHK_HIGH -> LOW, counter cleared, on any sample of 0.
REQ-019 CHK_HIGH -> HIGH on the edge at which THRESH consecutive 1 samples have been seen; level rises and press pulses on that same edge.
REQ-020 HIGH/CHK_LOW mirror REQ-018/019 with polarity swapped; release pulses on entry to LOW.
REQ-021 Latency: btn_in first sampled high at edge E and held -> level and press asserted after edge E+THRESH+1; a glitch of THRESH-1 cycles or less shall never change level.
REQ-022 Debounce counter width shall be $clog2(THRESH+1); it shall saturate, never wrap.
REQ-023 Hold counter shall clear on entry to HIGH and count each cycle in HIGH or CHK_LOW; hold pulses exactly once when it reaches HOLD_CYC.
REQ-024 After hold, with rpt_en set, rpt shall pulse every RPT_CYC cycles, the first RPT_CYC cycles after hold, until level falls.
REQ-025 rpt_en deasserted mid-hold shall suppress further rpt pulses and reset the repeat counter; reasserting restarts the full RPT_CYC period.
REQ-026 Entry to LOW shall clear hold and repeat counters; no hold/rpt pulse in the same cycle as release.
REQ-027 Channels shall be fully independent; simultaneous events on several channels shall each produce their own pulses in the same cycle.
REQ-028 press, release, hold and rpt shall never be high for two consecutive cycles on one channel.

Reset
REQ-029 While rst_n is low all synchronisers, counters, FSMs (LOW) and outputs shall be 0, asynchronously.
REQ-030 Reset mid-qualification or mid-hold shall discard progress; a button held through reset release shall produce press THRESH+2 edges after release.

Structure
REQ-031 FSM state enum and default timing constants shall live in shared package debounce_pkg.
REQ-032 Per-channel logic shall be one sub-module, debounce_channel, instantiated N_CH times by generate; top holds only instantiation and any_press.

Verification (N_CH=2, THRESH=4, HOLD_CYC=12, RPT_CYC=5)
REQ-033 Ch0 held high from edge 10 -> level[0] and press[0] after edge 15, press[0] low after edge 16.
REQ-034 Ch0 3-cycle high glitch, repeated 5 times -> level, press stay 0 throughout.
REQ-035 Ch1 held high 40 cycles, rpt_en=1 -> hold[1] 12 cycles after press, rpt[1] at +5 and +10 thereafter, release 5 edges after drop.
REQ-036 Both channels rise same edge, INV_MASK=2'b10 with ch1 driven low -> press=2'b11 same cycle, any_press=1 once.
REQ-037 rst_n pulsed low at cycle 3 of qualification, input held -> level 0 during reset, press 6 edges after rst_n rises.
REQ-038 rpt_en dropped after first rpt, raised 2 cycles later -> next rpt exactly 5 cycles after re-raise.
